channel_accumulator: RTL and testbench

CHANNEL_ACCUMULATOR -- requirements
Module: channel_accumulator

---
 rtl/channel_accumulator.sv | 116 +++++++++++
 tb/tb_channel_accumulator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/channel_accumulator.sv
// Frame accumulator: sums NUM_CH samples per frame into a guard-extended result,
// with optional two's-complement arithmetic and saturation on overflow.
module channel_accumulator #(
   parameter int WIDTH    = 19,
   parameter int NUM_CH   = 4,
   parameter int GUARD    = 2,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH+GUARD-1:0]   out_sum,
   output logic                     out_ovf
);

   localparam int   OUT_W     = WIDTH + GUARD;
   localparam int   CNT_W     = $clog2(NUM_CH);
   localparam logic IS_SIGNED = (SIGNED != 0);
   localparam logic IS_SAT    = (SATURATE != 0);

   typedef enum logic {ACCUM, HOLD} state_e;

   state_e             state_q, state_d;
   logic [OUT_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   chCnt_q, chCnt_d;
   logic               ovf_q, ovf_d;

   logic               inSign;
   logic [OUT_W:0]     inExt;
   logic [OUT_W:0]     accExt;
   logic [OUT_W:0]     exact;
   logic               stepOvf;
   logic [OUT_W-1:0]   satBound;
   logic [OUT_W-1:0]   stepVal;
   logic               lastCh;

   // One extra bit of headroom makes every single-step overflow visible in the top two bits.
   assign inSign = IS_SIGNED ? in_data[WIDTH-1] : 1'b0;
   assign inExt  = {{(GUARD + 1){inSign}}, in_data};
   assign accExt = {(IS_SIGNED ? acc_q[OUT_W-1] : 1'b0), acc_q};
   assign exact  = accExt + inExt;
   assign lastCh = (chCnt_q == CNT_W'(NUM_CH - 1));

   always_comb begin
      stepOvf  = 1'b0;
      satBound = '1;
      if (IS_SIGNED) begin
         stepOvf  = exact[OUT_W] ^ exact[OUT_W-1];
         satBound = exact[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
         stepOvf  = exact[OUT_W];
         satBound = '1;
      end
      stepVal = (stepOvf && IS_SAT) ? satBound : exact[OUT_W-1:0];
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      chCnt_d = chCnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         ACCUM: begin
            if (flush) begin
               acc_d   = '0;
               chCnt_d = '0;
               ovf_d   = 1'b0;
            end else if (in_valid) begin
               acc_d = stepVal;
               ovf_d = ovf_q | stepOvf;
               if (lastCh) begin
                  state_d = HOLD;
               end else begin
                  chCnt_d = chCnt_q + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            // The finished frame stays put until the consumer takes it; flush has no effect here.
            if (out_ready) begin
               state_d = ACCUM;
               acc_d   = '0;
               chCnt_d = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         chCnt_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         chCnt_q <= chCnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_channel_accumulator.sv
// Directed bench for channel_accumulator: four instances share stimulus so the
// unsigned, saturating, wrapping and signed variants are checked on the same frames.
module tb_channel_accumulator;

   logic        clk = 1'b0;
   logic        rst, flush, inValid, outReady;
   logic [18:0] inData;

   logic        inReady0, inReady1, inReady2, inReady3;
   logic        outValid0, outValid1, outValid2, outValid3;
   logic [20:0] outSum0, outSum3;
   logic [19:0] outSum1, outSum2;
   logic        outOvf0, outOvf1, outOvf2, outOvf3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   channel_accumulator u0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady0),
      .in_data(inData), .out_valid(outValid0), .out_ready(outReady),
      .out_sum(outSum0), .out_ovf(outOvf0));

   channel_accumulator #(.GUARD(1), .SATURATE(1)) u1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady1),
      .in_data(inData), .out_valid(outValid1), .out_ready(outReady),
      .out_sum(outSum1), .out_ovf(outOvf1));

   channel_accumulator #(.GUARD(1), .SATURATE(0)) u2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady2),
      .in_data(inData), .out_valid(outValid2), .out_ready(outReady),
      .out_sum(outSum2), .out_ovf(outOvf2));

   channel_accumulator #(.SIGNED(1)) u3 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady3),
      .in_data(inData), .out_valid(outValid3), .out_ready(outReady),
      .out_sum(outSum3), .out_ovf(outOvf3));

   typedef struct {
      logic [3:0][18:0] d;
      logic [20:0]      sum0;
      logic             ovf0;
      logic [19:0]      sum1;
      logic             ovf1;
      logic [19:0]      sum2;
      logic             ovf2;
      logic [20:0]      sum3;
      logic             ovf3;
   } vec_t;

   localparam int NV = 6;
   vec_t vecs [NV];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Sends four samples on back-to-back cycles; element 0 goes first.
   task automatic applyStimulus(input logic [3:0][18:0] d);
      for (int k = 0; k < 4; k++) begin
         inValid = 1'b1;
         inData  = d[k];
         tick();
      end
      inValid = 1'b0;
      inData  = '0;
   endtask

   task automatic handshake();
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      checkOutput("in_ready after handshake", {31'd0, inReady0}, 32'd1);
      checkOutput("out_valid after handshake", {31'd0, outValid0}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{{19'd4, 19'd3, 19'd2, 19'd1},
                  21'd10, 1'b0, 20'd10, 1'b0, 20'd10, 1'b0, 21'd10, 1'b0};
      vecs[1] = '{{19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF},
                  21'h1FFFFC, 1'b0, 20'hFFFFF, 1'b1, 20'hFFFFC, 1'b1, 21'h1FFFFC, 1'b0};
      vecs[2] = '{{19'h40000, 19'h40000, 19'h40000, 19'h40000},
                  21'h100000, 1'b0, 20'hFFFFF, 1'b1, 20'h00000, 1'b1, 21'h100000, 1'b0};
      vecs[3] = '{{19'h3FFFF, 19'h3FFFF, 19'h3FFFF, 19'h3FFFF},
                  21'h0FFFFC, 1'b0, 20'hFFFFC, 1'b0, 20'hFFFFC, 1'b0, 21'h0FFFFC, 1'b0};
      vecs[4] = '{{19'h00000, 19'h7FFFE, 19'h00005, 19'h7FFFF},
                  21'h100002, 1'b0, 20'hFFFFF, 1'b1, 20'h00002, 1'b1, 21'h000002, 1'b0};
      vecs[5] = '{{19'h0, 19'h0, 19'h0, 19'h0},
                  21'h0, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0, 21'h0, 1'b0};

      rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0; inData = '0;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset in_ready", {31'd0, inReady0}, 32'd1);
      checkOutput("reset out_valid", {31'd0, outValid0}, 32'd0);
      checkOutput("reset out_sum", {11'd0, outSum0}, 32'd0);
      checkOutput("reset out_ovf", {31'd0, outOvf0}, 32'd0);

      for (int v = 0; v < NV; v++) begin
         applyStimulus(vecs[v].d);
         checkOutput($sformatf("v%0d out_valid", v), {31'd0, outValid0}, 32'd1);
         checkOutput($sformatf("v%0d in_ready", v), {31'd0, inReady0}, 32'd0);
         checkOutput($sformatf("v%0d sum u0", v), {11'd0, outSum0}, {11'd0, vecs[v].sum0});
         checkOutput($sformatf("v%0d ovf u0", v), {31'd0, outOvf0}, {31'd0, vecs[v].ovf0});
         checkOutput($sformatf("v%0d sum u1", v), {12'd0, outSum1}, {12'd0, vecs[v].sum1});
         checkOutput($sformatf("v%0d ovf u1", v), {31'd0, outOvf1}, {31'd0, vecs[v].ovf1});
         checkOutput($sformatf("v%0d sum u2", v), {12'd0, outSum2}, {12'd0, vecs[v].sum2});
         checkOutput($sformatf("v%0d ovf u2", v), {31'd0, outOvf2}, {31'd0, vecs[v].ovf2});
         checkOutput($sformatf("v%0d sum u3", v), {11'd0, outSum3}, {11'd0, vecs[v].sum3});
         checkOutput($sformatf("v%0d ovf u3", v), {31'd0, outOvf3}, {31'd0, vecs[v].ovf3});
         handshake();
      end

      // Backpressure: HOLD must freeze and ignore incoming samples.
      applyStimulus({19'd4, 19'd3, 19'd2, 19'd1});
      inValid = 1'b1;
      inData  = 19'd100;
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("stall%0d out_valid", c), {31'd0, outValid0}, 32'd1);
         checkOutput($sformatf("stall%0d in_ready", c), {31'd0, inReady0}, 32'd0);
         checkOutput($sformatf("stall%0d out_sum", c), {11'd0, outSum0}, 32'd10);
         checkOutput($sformatf("stall%0d out_ovf", c), {31'd0, outOvf0}, 32'd0);
         tick();
      end
      inValid = 1'b0;
      handshake();
      applyStimulus({19'd1, 19'd1, 19'd1, 19'd1});
      checkOutput("post-stall sum", {11'd0, outSum0}, 32'd4);
      handshake();

      // Flush drops the partial frame and the sample presented with it.
      inValid = 1'b1; inData = 19'd7; tick(); tick();
      flush = 1'b1; inData = 19'd9; tick();
      flush = 1'b0; inValid = 1'b0;
      checkOutput("flush in_ready", {31'd0, inReady0}, 32'd1);
      checkOutput("flush out_sum", {11'd0, outSum0}, 32'd0);
      applyStimulus({19'd1, 19'd1, 19'd1, 19'd1});
      checkOutput("post-flush valid", {31'd0, outValid0}, 32'd1);
      checkOutput("post-flush sum", {11'd0, outSum0}, 32'd4);

      // Flush in HOLD is ignored.
      flush = 1'b1; tick(); flush = 1'b0;
      checkOutput("hold-flush valid", {31'd0, outValid0}, 32'd1);
      checkOutput("hold-flush sum", {11'd0, outSum0}, 32'd4);
      handshake();

      // Idle gaps inside a frame leave the accumulator untouched.
      inValid = 1'b1; inData = 19'd3; tick();
      inValid = 1'b0; tick(); tick();
      checkOutput("gap partial sum", {11'd0, outSum0}, 32'd3);
      inValid = 1'b1; inData = 19'd3; tick(); tick();
      inValid = 1'b0; tick();
      checkOutput("gap not done", {31'd0, outValid0}, 32'd0);
      inValid = 1'b1; inData = 19'd3; tick();
      inValid = 1'b0;
      checkOutput("gap done valid", {31'd0, outValid0}, 32'd1);
      checkOutput("gap sum", {11'd0, outSum0}, 32'd12);
      handshake();

      // Reset mid-frame, with a sample presented on the reset edge.
      inValid = 1'b1; inData = 19'd50; tick(); tick(); tick();
      rst = 1'b1; tick();
      rst = 1'b0; inValid = 1'b0;
      checkOutput("mid rst sum", {11'd0, outSum0}, 32'd0);
      applyStimulus({19'd5, 19'd5, 19'd5, 19'd5});
      checkOutput("after rst valid", {31'd0, outValid0}, 32'd1);
      checkOutput("after rst sum", {11'd0, outSum0}, 32'd20);
      checkOutput("after rst ovf", {31'd0, outOvf0}, 32'd0);

      // Reset in HOLD loses the pending sum.
      rst = 1'b1; tick(); rst = 1'b0;
      checkOutput("hold rst valid", {31'd0, outValid0}, 32'd0);
      checkOutput("hold rst in_ready", {31'd0, inReady0}, 32'd1);
      checkOutput("hold rst sum", {11'd0, outSum0}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
